// File: rtl/posit_result_checker.sv
// Pairs DUT and golden posit results from two valid/ready streams and compares them.
// Define POSIT_CHK_TOL_EN to also accept pairs one two's-complement step apart.
module posit_result_checker #(
    parameter int N     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] total,
    input  logic             dut_valid,
    input  logic [N-1:0]     dut_data,
    output logic             dut_ready,
    input  logic             exp_valid,
    input  logic [N-1:0]     exp_data,
    output logic             exp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [N-1:0]     first_err_dut,
    output logic [N-1:0]     first_err_exp,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

    state_t           state;
    state_t           state_next;
    logic [N-1:0]     dbuf;
    logic [N-1:0]     ebuf;
    logic             dbuf_v;
    logic             ebuf_v;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] total_q;

    logic running;
    logic go;
    logic fire;
    logic last;
    logic dut_take;
    logic exp_take;
    logic is_match;

    assign running   = (state == RUN);
    assign go        = start && !running;
    assign fire      = running && dbuf_v && ebuf_v;
    assign last      = fire && ((idx + CNT_W'(1)) == total_q);
    assign dut_ready = running && (!dbuf_v || fire);
    assign exp_ready = running && (!ebuf_v || fire);
    assign dut_take  = dut_ready && dut_valid;
    assign exp_take  = exp_ready && exp_valid;

    assign busy = running;
    assign done = (state == DONE);
    assign pass = done && (err_count == '0);

`ifdef POSIT_CHK_TOL_EN
    logic [N:0] diff;
    logic       near;

    // Sign-extend so that e.g. 0x7F vs 0x80 is not seen as one step apart.
    always_comb begin
        diff     = {dbuf[N-1], dbuf} - {ebuf[N-1], ebuf};
        near     = ((diff == (N+1)'(1)) || (diff == {(N+1){1'b1}}))
                   && (dbuf != NAR) && (ebuf != NAR);
        is_match = (dbuf == ebuf) || near;
    end
`else
    // NaR equals only NaR, which plain bitwise equality already gives.
    always_comb begin
        is_match = (dbuf == ebuf);
    end
`endif

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (total == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbuf          <= '0;
            ebuf          <= '0;
            dbuf_v        <= 1'b0;
            ebuf_v        <= 1'b0;
            idx           <= '0;
            total_q       <= '0;
            err_count     <= '0;
            first_err_idx <= '0;
            first_err_dut <= '0;
            first_err_exp <= '0;
            mismatch      <= 1'b0;
            mismatch_idx  <= '0;
        end else begin
            mismatch <= 1'b0;
            if (go) begin
                total_q       <= total;
                dbuf          <= '0;
                ebuf          <= '0;
                dbuf_v        <= 1'b0;
                ebuf_v        <= 1'b0;
                idx           <= '0;
                err_count     <= '0;
                first_err_idx <= '0;
                first_err_dut <= '0;
                first_err_exp <= '0;
            end else begin
                if (dut_take) begin
                    dbuf   <= dut_data;
                    dbuf_v <= 1'b1;
                end else if (fire) begin
                    dbuf_v <= 1'b0;
                end
                if (exp_take) begin
                    ebuf   <= exp_data;
                    ebuf_v <= 1'b1;
                end else if (fire) begin
                    ebuf_v <= 1'b0;
                end
                if (fire) begin
                    idx <= idx + CNT_W'(1);
                    if (!is_match) begin
                        if (err_count != {CNT_W{1'b1}}) begin
                            err_count <= err_count + CNT_W'(1);
                        end
                        mismatch     <= 1'b1;
                        mismatch_idx <= idx;
                        if (err_count == '0) begin
                            first_err_idx <= idx;
                            first_err_dut <= dbuf;
                            first_err_exp <= ebuf;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_posit_result_checker.sv
// Directed and randomized bench for posit_result_checker against a pair-list model.
module tb_posit_result_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] total;
    logic        dut_valid;
    logic [7:0]  dut_data;
    logic        dut_ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] err_count;
    logic [15:0] first_err_idx;
    logic [7:0]  first_err_dut;
    logic [7:0]  first_err_exp;
    logic        mismatch;
    logic [15:0] mismatch_idx;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  dq[$];
    logic [7:0]  eq[$];
    logic [15:0] got_mm[$];
    logic [15:0] exp_mm[$];

    posit_result_checker #(.N(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .total        (total),
        .dut_valid    (dut_valid),
        .dut_data     (dut_data),
        .dut_ready    (dut_ready),
        .exp_valid    (exp_valid),
        .exp_data     (exp_data),
        .exp_ready    (exp_ready),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .first_err_idx(first_err_idx),
        .first_err_dut(first_err_dut),
        .first_err_exp(first_err_exp),
        .mismatch     (mismatch),
        .mismatch_idx (mismatch_idx)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mismatch === 1'b1) got_mm.push_back(mismatch_idx);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic bit ref_match(input logic [7:0] d, input logic [7:0] e);
        int a;
        int b;
        a = $signed(d);
        b = $signed(e);
        if (d == e) return 1'b1;
`ifdef POSIT_CHK_TOL_EN
        if (d == 8'h80 || e == 8'h80) return 1'b0;
        return (a - b == 1) || (b - a == 1);
`else
        return (a - b == 0);
`endif
    endfunction

    task automatic arm(input int t);
        @(negedge clk);
        got_mm.delete();
        start = 1'b1;
        total = 16'(t);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input string tag, input int dlead, input int elead,
                        input bit gaps, input int exp_cyc);
        int  di = 0;
        int  ei = 0;
        int  cyc = 0;
        bit  da;
        bit  ea;
        while (done !== 1'b1 && cyc < 400) begin
            dut_valid = (cyc >= dlead) && (di < dq.size())
                        && (!gaps || $urandom_range(0, 2) != 0);
            exp_valid = (cyc >= elead) && (ei < eq.size())
                        && (!gaps || $urandom_range(0, 2) != 0);
            dut_data = dut_valid ? dq[di] : 8'($urandom);
            exp_data = exp_valid ? eq[ei] : 8'($urandom);
            if (ei > di) chk({tag, "_exp_ready_skew"}, exp_ready, 0);
            if (di > ei) chk({tag, "_dut_ready_skew"}, dut_ready, 0);
            da = dut_valid && dut_ready;
            ea = exp_valid && exp_ready;
            @(posedge clk);
            cyc++;
            if (da) di++;
            if (ea) ei++;
            @(negedge clk);
        end
        dut_valid = 1'b0;
        exp_valid = 1'b0;
        chk({tag, "_timeout_done"}, done, 1);
        if (exp_cyc > 0) chk({tag, "_cycles"}, cyc, exp_cyc);
    endtask

    task automatic verify(input string tag, input int t);
        int          errs = 0;
        logic [15:0] fi = 0;
        logic [7:0]  fd = 0;
        logic [7:0]  fe = 0;
        int          n;
        exp_mm.delete();
        for (int i = 0; i < t; i++) begin
            if (!ref_match(dq[i], eq[i])) begin
                if (errs == 0) begin
                    fi = 16'(i);
                    fd = dq[i];
                    fe = eq[i];
                end
                errs++;
                exp_mm.push_back(16'(i));
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_pass"}, pass, (errs == 0));
        chk({tag, "_err_count"}, err_count, errs);
        chk({tag, "_first_idx"}, first_err_idx, fi);
        chk({tag, "_first_dut"}, first_err_dut, fd);
        chk({tag, "_first_exp"}, first_err_exp, fe);
        chk({tag, "_dut_ready"}, dut_ready, 0);
        chk({tag, "_mm_count"}, got_mm.size(), exp_mm.size());
        n = (got_mm.size() < exp_mm.size()) ? got_mm.size() : exp_mm.size();
        for (int i = 0; i < n; i++) chk({tag, "_mm_idx"}, got_mm[i], exp_mm[i]);
    endtask

    task automatic load(input logic [7:0] d[], input logic [7:0] e[]);
        dq.delete();
        eq.delete();
        foreach (d[i]) dq.push_back(d[i]);
        foreach (e[i]) eq.push_back(e[i]);
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] v;
        int         k;
        rst       = 1'b1;
        start     = 1'b0;
        total     = '0;
        dut_valid = 1'b0;
        dut_data  = '0;
        exp_valid = 1'b0;
        exp_data  = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_readies", {dut_ready, exp_ready}, 0);
        chk("rst_err", err_count, 0);
        rst = 1'b0;
        @(negedge clk);

        load('{8'h40, 8'h48, 8'h00, 8'h80}, '{8'h40, 8'h48, 8'h00, 8'h80});
        arm(4);
        feed("exact", 0, 0, 1'b0, 5);
        verify("exact", 4);

        load('{8'h40, 8'h41, 8'h50}, '{8'h40, 8'h48, 8'h50});
        arm(3);
        feed("single", 0, 0, 1'b0, 4);
        verify("single", 3);

        arm(0);
        chk("restart_err_clear", err_count, 0);
        chk("restart_first_clear", first_err_dut, 0);
        chk("zero_done", done, 1);
        chk("zero_pass", pass, 1);
        chk("zero_busy", busy, 0);

        load('{8'h20, 8'h30}, '{8'h20, 8'h30});
        arm(2);
        feed("skew", 3, 0, 1'b0, 6);
        verify("skew", 2);

        load('{8'h41, 8'h7F}, '{8'h40, 8'h80});
        arm(2);
        feed("tol", 0, 0, 1'b0, 3);
        verify("tol", 2);

        load('{8'h11, 8'h22}, '{8'h11, 8'h22});
        arm(2);
        chk("ign_busy0", busy, 1);
        start = 1'b1;
        total = 16'd0;
        @(negedge clk);
        start = 1'b0;
        chk("ign_busy", busy, 1);
        chk("ign_done", done, 0);
        feed("ign", 0, 0, 1'b0, 0);
        verify("ign", 2);

        for (int r = 0; r < 3; r++) begin
            dq.delete();
            eq.delete();
            for (int i = 0; i < 24; i++) begin
                w = 8'($urandom);
                k = $urandom_range(0, 5);
                if (k == 0) w = 8'h80;
                v = w;
                if (k == 1) v = w + 8'd1;
                if (k == 2) v = w - 8'd1;
                if (k == 3) v = 8'($urandom);
                dq.push_back(w);
                eq.push_back(v);
            end
            arm(24);
            feed("rand", $urandom_range(0, 2), $urandom_range(0, 2), 1'b1, 0);
            verify("rand", 24);
        end

        load('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05},
             '{8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D});
        arm(5);
        dut_valid = 1'b1;
        exp_valid = 1'b1;
        dut_data  = 8'h01;
        exp_data  = 8'h09;
        repeat (3) @(negedge clk);
        chk("midrst_err_nz", (err_count != 0), 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_pass", pass, 0);
        chk("midrst_readies", {dut_ready, exp_ready}, 0);
        chk("midrst_err", err_count, 0);
        chk("midrst_first", {first_err_idx, first_err_dut, first_err_exp}, 0);
        chk("midrst_mm", mismatch, 0);
        dut_valid = 1'b0;
        exp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/posit_result_checker.md
# posit_result_checker

Synthesizable response checker for posit arithmetic units, sitting at the output end of the posit_adder vector flow. It receives DUT results and golden results on two independent valid/ready streams, pairs them in arrival order, and compares them. It counts mismatches, latches the first failing pair and signals completion after a programmed number of vectors. The checker runs in FPGA self-test and in simulation alongside the vector driver.

## Interface
- N, 8, posit word width in bits
- CNT_W, 16, width of the vector count, index and error counters

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; arms a run; honoured only in IDLE or DONE
- total  in  CNT_W  number of pairs to check; sampled on accepted start
- dut_valid  in  1  DUT result valid
- dut_data  in  N  DUT result posit
- dut_ready  out  1  checker accepts dut_data this cycle
- exp_valid  in  1  golden result valid
- exp_data  in  N  golden result posit
- exp_ready  out  1  checker accepts exp_data this cycle
- busy  out  1  state is RUN
- done  out  1  state is DONE
- pass  out  1  done and err_count == 0
- err_count  out  CNT_W  mismatches in current run, saturating at all-ones
- first_err_idx  out  CNT_W  0-based index of first mismatch
- first_err_dut  out  N  DUT word of first mismatch
- first_err_exp  out  N  golden word of first mismatch
- mismatch  out  1  one-cycle pulse per mismatching pair
- mismatch_idx  out  CNT_W  index of pair flagged by mismatch

## Operation
- States: IDLE, RUN, DONE.
- IDLE -> RUN on start with total != 0. IDLE -> DONE on start with total == 0.
- DONE -> RUN (or DONE) on start with the same rules. start in RUN is ignored.
- RUN -> DONE when the compare count reaches total.
- An accepted start clears err_count, the compare index, both buffers and the first_err_* fields to 0.
- Each side has a one-entry buffer (dbuf, ebuf) with a valid flag.
- fire = dbuf_v && ebuf_v, evaluated in RUN.
- dut_ready = RUN && (!dbuf_v || fire). exp_ready has the same form with ebuf_v.
- Readies depend only on registered state, never on the input valids.
- On fire:
  - Both buffers drain; a simultaneous new load refills them.
  - The compare index increments.
  - On mismatch: err_count increments unless saturated, and mismatch pulses with mismatch_idx set to the pre-increment index.
  - first_err_* latch only when err_count was 0.
- Match rule: bitwise equality of the dbuf and ebuf words. NaR (1 followed by N-1 zeros) matches only NaR.
- Words arriving after the run reaches total are not accepted, because ready is low outside RUN.

## Timing
- Reset values: busy=0, done=0, pass=0, mismatch=0, dut_ready=0, exp_ready=0. All counters, indices and first_err_* are 0. State is IDLE and buffers are empty.
- Latency: if the later of the two words is accepted at edge E, fire is high in cycle E..E+1. err_count, mismatch, mismatch_idx and the index update at edge E+1.
- Throughput: one pair per cycle when both sides stream continuously.
- done, and pass when applicable, rise at the same edge as the final compare update. busy falls at that edge.
- Skew: either side may run up to one word ahead. Its ready then stays low until the other side catches up.
- Reset mid-run returns all state to the reset values asynchronously. Partial results are discarded.

## Configuration
- POSIT_CHK_TOL_EN undefined: exact match only.
- POSIT_CHK_TOL_EN defined: a pair also matches when the two words, read as N-bit two's-complement integers, differ by exactly 1 (one-ULP rounding tolerance).
  - The tolerance does not apply when either word is NaR. Such pairs require exact equality.
  - Counters and handshake are unchanged.

## Test plan
- Exact stream: total=4, dut and exp both 0x40,0x48,0x00,0x80, both valids held high.
  - Required: 1 pair/cycle, no mismatch pulses, done and pass high 4 cycles after the first fire cycle, err_count=0.
- Single error: total=3, dut 0x40,0x41,0x50 vs exp 0x40,0x48,0x50.
  - Required: one mismatch pulse with mismatch_idx=1, first_err_idx=1, first_err_dut=0x41, first_err_exp=0x48.
  - At done: err_count=1, pass=0.
- Skew: exp words arrive 3 cycles before dut words, total=2.
  - Required: exp_ready low after ebuf fills until dbuf fills, pairs matched in order, pass=1.
- Tolerance: dut 0x41 vs exp 0x40, then dut 0x7F vs exp 0x80.
  - Required with POSIT_CHK_TOL_EN: first pair matches, second is a mismatch (NaR).
  - Required without POSIT_CHK_TOL_EN: both pairs are mismatches.
- Control corners:
  - start with total=0 -> done=1, pass=1 at the next edge.
  - start during RUN is ignored.
  - rst asserted mid-run -> all outputs return to reset values at once.
  - A new start after done clears err_count.
